cprv_hazard_ctrl: RTL
=====================

Name: cprv_hazard_ctrl

Overview:
- Scoreboard-based interlock controller between the ID stage and the EX stage of the cprv64g pipeline.
- Tracks in-flight destination-register writes, issued at ID and retired at WB.
- Gates the ID→EX valid/ready handshake so that an instruction never issues while a source register it reads still has a pending write.
- Also provides flush, in-flight status and a stall performance counter.

Parameters:
CNT_WIDTH, 2, width of each per-register pending-write counter; max in-flight writers per register = 2^CNT_WIDTH-1
WB_BYPASS, 1, 1 = a register retiring at WB this cycle with count 1 is treated as not pending (regfile write-through); 0 = no bypass
STALL_CNT_WIDTH, 32, width of the stall performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_id_i  in  1  ID holds a decoded instruction
rs1_addr_id_i  in  5  source 1 register index
rs1_used_id_i  in  1  instruction reads rs1
rs2_addr_id_i  in  5  source 2 register index
rs2_used_id_i  in  1  instruction reads rs2
rd_addr_id_i  in  5  destination register index
rd_en_id_i  in  1  instruction writes rd
ready_ex_i  in  1  EX can accept
valid_ex_o  out  1  gated valid to EX
ready_id_o  out  1  gated ready back to ID
wb_valid_i  in  1  WB retires a register write this cycle
wb_rd_addr_i  in  5  register retired at WB
flush_i  in  1  discard all in-flight tracking
busy_o  out  1  any counter nonzero
err_underflow_o  out  1  sticky: retire seen with counter 0
stall_cnt_o  out  STALL_CNT_WIDTH  cycles stalled by a hazard

Behaviour:
- State: cnt[1..31], each CNT_WIDTH bits. x0 is never tracked: it reads as 0 and x0 writes/retires are ignored.
- Reset (rst_n low, asynchronous): all cnt = 0, err_underflow_o = 0, stall_cnt_o = 0. This holds even when reset is asserted mid-operation.
- pend(r) = (r != 0) & (cnt[r] != 0) & ~(WB_BYPASS & wb_valid_i & wb_rd_addr_i == r & cnt[r] == 1).
- hazard = (rs1_used_id_i & pend(rs1)) | (rs2_used_id_i & pend(rs2)) | (rd_en_id_i & rd != 0 & cnt[rd] == max).
  - The third term is a saturation stall: a new writer cannot issue while its destination counter is full.
- Handshake outputs are combinational, with zero added latency:
  - valid_ex_o = valid_id_i & ~hazard
  - ready_id_o = ready_ex_i & ~hazard
- issue = valid_id_i & ready_ex_i & ~hazard.
- Counter update on the rising edge, in priority order:
  1. flush_i = 1: all cnt = 0. Issue and retire in the same cycle are ignored, and valid_ex_o is still computed normally.
  2. issue & rd_en & rd != 0: cnt[rd] += 1.
  3. wb_valid_i & wb_rd != 0: cnt[wb_rd] -= 1.
  4. Issue and retire to the same register in the same cycle: cnt unchanged, net 0.
  5. Retire when cnt == 0 (and not offset by a same-cycle issue to that register): cnt stays 0 and err_underflow_o sets.
- err_underflow_o is sticky and is cleared only by reset, not by flush.
- busy_o = OR of all cnt != 0, reflecting registered state.
- stall_cnt_o increments by 1 each cycle where valid_id_i & hazard. It saturates at all-ones and is not cleared by flush.
- A stall caused by ready_ex_i = 0 alone does not count.

Test Plan:
- Issue `addi x5` (rd_en, rd=5, ready_ex=1) with no WB → cnt[5]=1, busy_o=1. Next cycle `add x6,x5,x1` with rs1_used → valid_ex_o=0, ready_id_o=0, stall_cnt_o increments each cycle. Assert wb_valid with rd=5 → with WB_BYPASS=1 valid_ex_o=1 in that same cycle, and cnt[5]=0 afterwards.
- WB_BYPASS=0, same sequence → the instruction is still stalled in the retire cycle and issues the following cycle.
- Issue 3 writers to x7 back-to-back (CNT_WIDTH=2) → cnt[7]=3. A 4th writer to x7 (no source use) → hazard, valid_ex_o=0, until one retire → issues.
- With cnt[9]=1, issue a writer to x9 while wb retires x9 in the same cycle → cnt[9]=1, err_underflow_o=0.
- Several counters nonzero, assert flush_i together with an issue to x3 → all cnt=0, busy_o=0 next cycle. A following reader of x3 issues without stall.
- wb_valid with rd=4 while cnt[4]=0 → err_underflow_o=1 and stays 1 across flush. Issue with rd=0 and rs1=0 used → no stall and busy_o unchanged. Pulse rst_n low mid-stall → stall_cnt_o=0, err_underflow_o=0, all cnt=0 immediately.

Source files
------------

// File: rtl/cprv_hazard_ctrl_if.sv
// ID->EX handshake and WB retire bus seen by the hazard controller.
// master = pipeline side driving ID/WB; slave = the interlock controller.
interface cprv_hazard_ctrl_if;
  logic       valid_id_i;
  logic [4:0] rs1_addr_id_i;
  logic       rs1_used_id_i;
  logic [4:0] rs2_addr_id_i;
  logic       rs2_used_id_i;
  logic [4:0] rd_addr_id_i;
  logic       rd_en_id_i;
  logic       ready_ex_i;
  logic       valid_ex_o;
  logic       ready_id_o;
  logic       wb_valid_i;
  logic [4:0] wb_rd_addr_i;

  modport master (
    output valid_id_i, rs1_addr_id_i, rs1_used_id_i, rs2_addr_id_i, rs2_used_id_i,
    output rd_addr_id_i, rd_en_id_i, ready_ex_i, wb_valid_i, wb_rd_addr_i,
    input  valid_ex_o, ready_id_o
  );

  modport slave (
    input  valid_id_i, rs1_addr_id_i, rs1_used_id_i, rs2_addr_id_i, rs2_used_id_i,
    input  rd_addr_id_i, rd_en_id_i, ready_ex_i, wb_valid_i, wb_rd_addr_i,
    output valid_ex_o, ready_id_o
  );
endinterface

// File: rtl/cprv_hazard_ctrl.sv
// Scoreboard interlock between ID and EX: per-register pending-write counters
// gate the ID->EX handshake until every source operand has been written back.
module cprv_hazard_ctrl #(
  parameter int unsigned CNT_WIDTH       = 2,
  parameter bit          WB_BYPASS       = 1'b1,
  parameter int unsigned STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cprv_hazard_ctrl_if.slave          hz_if,
  input  logic                       flush_i,
  output logic                       busy_o,
  output logic                       err_underflow_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]       cnt_q [1:31];
  logic [CNT_WIDTH-1:0]       cnt_d [1:31];
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                       err_q, err_d;

  logic [CNT_WIDTH-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic [31:0]          inc_vec, dec_vec;
  logic                 pend_rs1, pend_rs2, sat_rd;
  logic                 hazard, issue, underflow;

  // x0 has no counter, so its lookups fall through to zero
  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    cnt_rd  = '0;
    for (int i = 1; i < 32; i++) begin
      if (hz_if.rs1_addr_id_i == 5'(i)) cnt_rs1 = cnt_q[i];
      if (hz_if.rs2_addr_id_i == 5'(i)) cnt_rs2 = cnt_q[i];
      if (hz_if.rd_addr_id_i  == 5'(i)) cnt_rd  = cnt_q[i];
    end
  end

  // A last outstanding write retiring this cycle is forwarded by the regfile
  assign pend_rs1 = (cnt_rs1 != '0) &
                    ~(WB_BYPASS & hz_if.wb_valid_i &
                      (hz_if.wb_rd_addr_i == hz_if.rs1_addr_id_i) & (cnt_rs1 == CNT_ONE));
  assign pend_rs2 = (cnt_rs2 != '0) &
                    ~(WB_BYPASS & hz_if.wb_valid_i &
                      (hz_if.wb_rd_addr_i == hz_if.rs2_addr_id_i) & (cnt_rs2 == CNT_ONE));
  assign sat_rd   = hz_if.rd_en_id_i & (hz_if.rd_addr_id_i != 5'd0) & (cnt_rd == CNT_MAX);

  assign hazard = (hz_if.rs1_used_id_i & pend_rs1) | (hz_if.rs2_used_id_i & pend_rs2) | sat_rd;
  assign issue  = hz_if.valid_id_i & hz_if.ready_ex_i & ~hazard;

  assign hz_if.valid_ex_o = hz_if.valid_id_i & ~hazard;
  assign hz_if.ready_id_o = hz_if.ready_ex_i & ~hazard;

  assign inc_vec = (issue & hz_if.rd_en_id_i) ? (32'd1 << hz_if.rd_addr_id_i) : 32'd0;
  assign dec_vec = hz_if.wb_valid_i ? (32'd1 << hz_if.wb_rd_addr_i) : 32'd0;

  always_comb begin
    underflow = 1'b0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) underflow = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hz_if.valid_id_i && hazard && !(&stall_q)) stall_d = stall_q + 1'b1;
    err_d = err_q | underflow;
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (cnt_q[i] != '0) busy_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt_o     = stall_q;
  assign err_underflow_o = err_q;

endmodule
